// File: rtl/vga_frame_sequencer.sv
// Per-frame controller: VSync edge detect, frame tick/count, scroll offset and
// SHOW/BLANK mode sequencing for the VGA pattern datapath.
module vga_frame_sequencer #(
    parameter int unsigned MODE_FRAMES  = 120,
    parameter int unsigned BLANK_FRAMES = 8,
    parameter int unsigned SPEED_W      = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vsync,
    input  logic               run,
    input  logic               step,
    input  logic               dir,
    input  logic [SPEED_W-1:0] speed,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_mode,
    output logic [9:0]         scroll_x,
    output logic [1:0]         mode,
    output logic               blank,
    output logic [8:0]         frame_no,
    output logic               frame_tick,
    output logic               paused
);

    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

    localparam logic [7:0] MODE_LAST  = 8'(MODE_FRAMES - 1);
    localparam logic [7:0] BLANK_LAST = 8'(BLANK_FRAMES - 1);

    state_t     state;
    logic [7:0] dwell;
    logic       vs_d;
    logic       step_d;
    logic       step_pend;

    logic       vs_edge;
    logic       adv;
    logic       step_arm;
    logic [9:0] speed_ext;

    assign vs_edge   = vsync & ~vs_d;
    assign adv       = vs_edge & (run | step_pend);
    assign step_arm  = ~run & (state != IDLE) & step & ~step_d;
    assign speed_ext = 10'(speed);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scroll_x   <= '0;
            mode       <= '0;
            blank      <= 1'b1;
            frame_no   <= '0;
            frame_tick <= 1'b0;
            paused     <= 1'b0;
            state      <= IDLE;
            dwell      <= '0;
            vs_d       <= 1'b1;
            step_d     <= 1'b0;
            step_pend  <= 1'b0;
        end else begin
            vs_d       <= vsync;
            step_d     <= step;
            frame_tick <= vs_edge;
            if (vs_edge) begin
                frame_no <= frame_no + 9'd1;
            end
            // Registered view of "run low and next state not IDLE".
            paused <= ~run & ((state != IDLE) | vs_edge | cfg_we);

            // An arm coinciding with an advance survives to the next advance.
            if (run) begin
                step_pend <= 1'b0;
            end else if (step_arm) begin
                step_pend <= 1'b1;
            end else if (adv) begin
                step_pend <= 1'b0;
            end

            if (state == IDLE) begin
                if (vs_edge) begin
                    state <= SHOW;
                    dwell <= '0;
                    blank <= 1'b0;
                end
            end else if (adv) begin
                scroll_x <= dir ? (scroll_x - speed_ext) : (scroll_x + speed_ext);
                if (state == SHOW) begin
                    if (dwell == MODE_LAST) begin
                        state <= BLANK;
                        dwell <= '0;
                        blank <= 1'b1;
                    end else begin
                        dwell <= dwell + 8'd1;
                    end
                end else begin
                    if (dwell == BLANK_LAST) begin
                        state <= SHOW;
                        dwell <= '0;
                        blank <= 1'b0;
                        mode  <= mode + 2'd1;
                    end else begin
                        dwell <= dwell + 8'd1;
                    end
                end
            end

            // Forced mode overrides any state/mode update above.
            if (cfg_we) begin
                mode  <= cfg_mode;
                dwell <= '0;
                state <= SHOW;
                blank <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_sequencer.sv
// Directed bench for vga_frame_sequencer: a per-frame reference model pushes
// expected outputs to a queue, popped and compared on each frame_tick.
module tb_vga_frame_sequencer;

    localparam int unsigned MF = 4;
    localparam int unsigned BF = 2;
    localparam int unsigned SW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          vsync;
    logic          run;
    logic          step;
    logic          dir;
    logic [SW-1:0] speed;
    logic          cfg_we;
    logic [1:0]    cfg_mode;
    logic [9:0]    scroll_x;
    logic [1:0]    mode;
    logic          blank;
    logic [8:0]    frame_no;
    logic          frame_tick;
    logic          paused;

    vga_frame_sequencer #(
        .MODE_FRAMES (MF),
        .BLANK_FRAMES(BF),
        .SPEED_W     (SW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vsync     (vsync),
        .run       (run),
        .step      (step),
        .dir       (dir),
        .speed     (speed),
        .cfg_we    (cfg_we),
        .cfg_mode  (cfg_mode),
        .scroll_x  (scroll_x),
        .mode      (mode),
        .blank     (blank),
        .frame_no  (frame_no),
        .frame_tick(frame_tick),
        .paused    (paused)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] scroll_x;
        logic [1:0] mode;
        logic       blank;
        logic [8:0] frame_no;
        logic       paused;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // Reference model: 0 = idle, 1 = show, 2 = blank
    int         m_state;
    int         m_dwell;
    logic [1:0] m_mode;
    logic [9:0] m_scroll;
    logic [8:0] m_frame;
    logic       m_blank;
    logic       m_pend;
    int         adv_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_dwell  = 0;
        m_mode   = 2'd0;
        m_scroll = 10'd0;
        m_frame  = 9'd0;
        m_blank  = 1'b1;
        m_pend   = 1'b0;
    endtask

    // One VSync pulse; optionally strobe cfg_we on the cycle of the rising edge.
    task automatic frame(input bit with_cfg, input logic [1:0] cm);
        exp_t e;
        bit   adv;
        bit   seen;
        adv     = run || m_pend;
        m_frame = m_frame + 9'd1;
        if (m_state == 0) begin
            m_state = 1;
            m_dwell = 0;
            m_blank = 1'b0;
        end else if (adv) begin
            adv_cnt++;
            if (dir) m_scroll = m_scroll - 10'(speed);
            else     m_scroll = m_scroll + 10'(speed);
            m_dwell++;
            if (m_state == 1 && m_dwell == MF) begin
                m_state = 2;
                m_dwell = 0;
                m_blank = 1'b1;
            end else if (m_state == 2 && m_dwell == BF) begin
                m_state = 1;
                m_dwell = 0;
                m_blank = 1'b0;
                m_mode  = m_mode + 2'd1;
            end
        end
        if (with_cfg) begin
            m_mode  = cm;
            m_dwell = 0;
            m_state = 1;
            m_blank = 1'b0;
        end
        if (adv) m_pend = 1'b0;
        e.scroll_x = m_scroll;
        e.mode     = m_mode;
        e.blank    = m_blank;
        e.frame_no = m_frame;
        e.paused   = !run && (m_state != 0);
        sb.push_back(e);

        @(negedge clk);
        vsync = 1'b1;
        if (with_cfg) begin
            cfg_we   = 1'b1;
            cfg_mode = cm;
        end
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cfg_we = 1'b0;
            if (frame_tick) begin
                seen = 1'b1;
                break;
            end
        end
        e = sb.pop_front();
        chk("frame_tick_seen", 32'(seen), 32'd1);
        if (seen) begin
            chk("scroll_x", 32'(scroll_x), 32'(e.scroll_x));
            chk("mode",     32'(mode),     32'(e.mode));
            chk("blank",    32'(blank),    32'(e.blank));
            chk("frame_no", 32'(frame_no), 32'(e.frame_no));
            chk("paused",   32'(paused),   32'(e.paused));
        end
        repeat (2) @(negedge clk);
        vsync = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int guard;
        int ticks;
        rst_n    = 1'b0;
        vsync    = 1'b0;
        run      = 1'b1;
        step     = 1'b0;
        dir      = 1'b0;
        speed    = 3'd3;
        cfg_we   = 1'b0;
        cfg_mode = 2'd0;
        adv_cnt  = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_blank", 32'(blank), 32'd1);
        chk("rst_frame_tick", 32'(frame_tick), 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_no_tick", 32'(frame_tick), 32'd0);

        // IDLE exit; tick must be a single pulse
        frame(1'b0, 2'd0);
        chk("exit_frame_no", 32'(frame_no), 32'd1);

        // Scroll forward then backward with wrap
        repeat (5) frame(1'b0, 2'd0);
        chk("scroll_fwd", 32'(scroll_x), 32'd15);
        chk("frame_no_6", 32'(frame_no), 32'd6);
        dir = 1'b1;
        repeat (6) frame(1'b0, 2'd0);
        chk("scroll_wrap", 32'(scroll_x), 32'd1021);

        // Mode sequencing through 24 advanced ticks
        repeat (13) frame(1'b0, 2'd0);
        chk("mode_wrap_24", 32'(mode), 32'd0);
        chk("adv_count_24", 32'(adv_cnt), 32'd24);

        // Pause, then single-step
        run = 1'b0;
        dir = 1'b0;
        repeat (3) frame(1'b0, 2'd0);
        chk("pause_frame_no", 32'(frame_no), 32'd28);
        @(negedge clk);
        step = 1'b1;
        m_pend = 1'b1;
        frame(1'b0, 2'd0);
        frame(1'b0, 2'd0);
        step = 1'b0;
        chk("step_one_adv", 32'(adv_cnt), 32'd25);

        // cfg_we coincident with a SHOW->BLANK tick
        run = 1'b1;
        guard = 0;
        while (!(m_state == 1 && m_dwell == MF - 1) && guard < 20) begin
            frame(1'b0, 2'd0);
            guard++;
        end
        frame(1'b1, 2'd2);
        chk("cfg_mode", 32'(mode), 32'd2);
        chk("cfg_blank", 32'(blank), 32'd0);

        // Reset mid-BLANK with vsync held high across release
        guard = 0;
        while (m_state != 2 && guard < 20) begin
            frame(1'b0, 2'd0);
            guard++;
        end
        chk("in_blank", 32'(blank), 32'd1);
        @(negedge clk);
        vsync = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_scroll", 32'(scroll_x), 32'd0);
        chk("async_mode", 32'(mode), 32'd0);
        chk("async_blank", 32'(blank), 32'd1);
        chk("async_frame_no", 32'(frame_no), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        ticks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (frame_tick) ticks++;
        end
        chk("no_tick_after_rst", 32'(ticks), 32'd0);
        vsync = 1'b0;
        repeat (2) @(negedge clk);
        frame(1'b0, 2'd0);
        chk("post_rst_exit_blank", 32'(blank), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_frame_sequencer.md
Name: vga_frame_sequencer

Overview:
Per-frame controller for the VGA pattern datapath. It detects the VSync rising edge synchronously in the pixel clock domain and produces a one-cycle frame tick. On each tick it advances a horizontal scroll offset and a free-running frame counter, and it cycles pattern modes through SHOW/BLANK dwell phases. It sits between the hvsync generator and the pixel colour logic; run, step, direction and speed come from the dedicated inputs.

Parameters:
MODE_FRAMES, 120, ticks spent in SHOW before entering BLANK (1..255)
BLANK_FRAMES, 8, ticks spent in BLANK before the next mode (1..255)
SPEED_W, 3, width of the speed input

Ports:
clk  input  1  pixel clock
rst_n  input  1  asynchronous active-low reset
vsync  input  1  VSync from the hvsync generator (same clock domain, active high)
run  input  1  level; 1 = advance every frame, 0 = paused
step  input  1  level; a 0->1 transition while paused arms a single-frame advance
dir  input  1  scroll direction; 0 = add speed, 1 = subtract speed
speed  input  SPEED_W  scroll pixels per advanced frame
cfg_we  input  1  one-cycle strobe: force mode
cfg_mode  input  2  mode value written on cfg_we
scroll_x  output  10  horizontal offset added to hpos by the datapath
mode  output  2  current pattern mode
blank  output  1  1 = datapath drives black
frame_no  output  9  free-running frame count
frame_tick  output  1  one-cycle pulse per frame
paused  output  1  1 when run=0 and state is not IDLE

Behaviour:
- Reset is asynchronous and active-low: one clock, and all flops clear asynchronously on rst_n low. Reset values: scroll_x=0, mode=0, blank=1, frame_no=0, frame_tick=0, state=IDLE, dwell=0, vs_d=1, step_d=0, step_pend=0. vs_d resets to 1 so no false edge occurs out of reset.
- Edge detect: vs_d <= vsync every cycle. edge = vsync & ~vs_d.
- On the clock edge where edge=1: frame_tick<=1 (otherwise 0) and frame_no<=frame_no+1 (wraps 511->0). Both become visible in the cycle after vsync is first sampled high.
- adv = edge & (run | step_pend). All per-frame updates below happen on that same edge, so outputs change together with frame_tick.
- step: step_d <= step. If run=0 and state!=IDLE and step&~step_d, set step_pend. Clear step_pend on any adv. If the arm and the adv occur in the same cycle, the arm is consumed by the next adv. run=1 clears step_pend.
- Scroll on adv while in SHOW or BLANK: scroll_x <= scroll_x +/- speed, zero-extended, modulo 1024. speed=0 leaves scroll_x unchanged.
- State machine, with dwell as an 8-bit tick counter:
  - IDLE: blank=1. The first edge (regardless of run) moves to SHOW with dwell=0 and blank=0. No scroll on this edge.
  - SHOW: on adv, dwell+1. When dwell reaches MODE_FRAMES-1 on an adv: go to BLANK, dwell=0, blank=1.
  - BLANK: on adv, dwell+1. When dwell reaches BLANK_FRAMES-1 on an adv: go to SHOW, dwell=0, blank=0, mode<=mode+1 (3 wraps to 0).
- Pause (run=0): state, dwell, mode, scroll_x and blank are all held. frame_no and frame_tick keep running.
- cfg_we: mode<=cfg_mode, dwell=0, state=SHOW, blank=0 on the next edge. It takes priority over a simultaneous adv transition and the mode increment. scroll_x still updates if adv. cfg_we in IDLE also exits IDLE.
- Reset mid-frame: all state returns to reset values immediately. The first vsync rising edge after release is the IDLE exit.
- Outputs are registered. Combinational paths from inputs to outputs are not permitted.

Test Plan:
1. Reset release, vsync low for 10 cycles then high -> frame_tick is a single pulse one cycle after vsync rises; frame_no=1; state SHOW; blank=0; scroll_x=0.
2. run=1, speed=3, dir=0, 5 vsync pulses after IDLE exit -> scroll_x=15, frame_no=6. Then dir=1, 6 pulses -> scroll_x=1021 (wrap).
3. MODE_FRAMES=4, BLANK_FRAMES=2, run=1 -> blank rises on the 4th advanced tick and falls on the 6th. mode goes 0->1 on the 6th tick; the 24th tick returns mode to 0.
4. run=0 for 3 frames -> scroll_x/dwell/mode frozen and paused=1, while frame_no still increments by 3. Then one step pulse -> exactly one advance on the next tick. A second step held high produces no further advance.
5. cfg_we with cfg_mode=2 on the same cycle as a SHOW->BLANK tick -> mode=2, blank=0, dwell=0; scroll_x still advanced by speed.
6. rst_n asserted mid-BLANK with scroll_x=200 -> all outputs return to reset values asynchronously, and vsync held high through release generates no tick.
